// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R0-R15, PC, IR, MAR, MDR, Y, Z(64), HI, LO
// and a combinational ALU, all sequenced by externally supplied strobes.
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        PCin,
  input  logic        Zin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        IRin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic [4:0]  opcode
);

  typedef enum logic [4:0] {
    OP_LD   = 5'd0,
    OP_LDI  = 5'd1,
    OP_ST   = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_SHR  = 5'd5,
    OP_SHRA = 5'd6,
    OP_SHL  = 5'd7,
    OP_ROR  = 5'd8,
    OP_ROL  = 5'd9,
    OP_AND  = 5'd10,
    OP_OR   = 5'd11,
    OP_ADDI = 5'd12,
    OP_ANDI = 5'd13,
    OP_ORI  = 5'd14,
    OP_MUL  = 5'd15,
    OP_DIV  = 5'd16,
    OP_NEG  = 5'd17,
    OP_NOT  = 5'd18
  } alu_op_e;

  logic [31:0] r [16];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo;
  logic [63:0] z;
  logic [31:0] bus;
  logic [31:0] c_imm;
  logic [63:0] c;

  logic [4:0]         sh;
  logic [63:0]        rot_r, rot_l;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  assign c_imm = {{13{ir[18]}}, ir[18:0]};

  // Lowest-priority drivers are applied first so higher-priority ones win.
  always_comb begin
    bus = '0;
    if (Cout)     bus = c_imm;
    if (MDRout)   bus = mdr;
    if (PCout)    bus = pc;
    if (Zlowout)  bus = z[31:0];
    if (Zhighout) bus = z[63:32];
    if (LOout)    bus = lo;
    if (HIout)    bus = hi;
    for (int unsigned i = 16; i > 0; i--) begin
      if (Rout[i-1]) bus = r[i-1];
    end
  end

  assign sh    = bus[4:0];
  assign rot_r = {y, y} >> sh;
  assign rot_l = {y, y} << sh;
  assign prod  = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});

  // Divide-by-zero and MIN/-1 are resolved explicitly rather than left to the
  // divider, so the quotient is only taken for well-defined operands.
  always_comb begin
    quo = '0;
    rem = '0;
    if (bus == '0) begin
      quo = '1;
      rem = $signed(y);
    end else if (y == 32'h8000_0000 && bus == '1) begin
      quo = 32'sh8000_0000;
      rem = '0;
    end else begin
      quo = $signed(y) / $signed(bus);
      rem = $signed(y) % $signed(bus);
    end
  end

  always_comb begin
    c = '0;
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: c = {32'h0, y + bus};
      OP_SUB:          c = {32'h0, y - bus};
      OP_SHR:          c = {32'h0, y >> sh};
      OP_SHRA:         c = {32'h0, $signed(y) >>> sh};
      OP_SHL:          c = {32'h0, y << sh};
      OP_ROR:          c = {32'h0, rot_r[31:0]};
      OP_ROL:          c = {32'h0, rot_l[63:32]};
      OP_AND, OP_ANDI: c = {32'h0, y & bus};
      OP_OR, OP_ORI:   c = {32'h0, y | bus};
      OP_MUL:          c = prod;
      OP_DIV:          c = {rem, quo};
      OP_NEG:          c = {32'h0, -bus};
      OP_NOT:          c = {32'h0, ~bus};
      default:         c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned i = 0; i < 16; i++) r[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (Rin[i]) r[i] <= bus;
      end
      if (PCin)  pc  <= IncPC ? pc + 32'd1 : bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? Mdatain : bus;
      if (Yin)   y   <= bus;
      if (Zin)   z   <= c;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed and randomized checks of the datapath against an arithmetic
// reference model; registers are observed hierarchically.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, IncPC;
  logic [15:0] Rin, Rout;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0]  opcode;

  int errors = 0;
  int checks = 0;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IRin(IRin), .PCout(PCout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .opcode(opcode)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clear = 0; Read = 0; IncPC = 0; Rin = '0; Rout = '0;
    PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0; IRin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
    opcode = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic load_reg(input int unsigned i, input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1; Rin[i] = 1;
    tick();
  endtask

  task automatic alu_run(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res);
    mem_to_mdr(a);
    MDRout = 1; Yin = 1;
    tick();
    mem_to_mdr(b);
    MDRout = 1; Zin = 1; opcode = opc;
    tick();
    res = dut.z;
  endtask

  // Reference ALU built from plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] ref_alu(input logic [4:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, q, rm, sp;
    longint unsigned ua, ub, p;
    int unsigned     s;
    logic [31:0]     lo_w, hi_w;
    ua = a; ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = b % 32;
    p  = 64'd1 << s;
    sp = longint'(p);
    lo_w = '0; hi_w = '0;
    case (opc)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo_w = 32'(ua + ub);
      5'd4:  lo_w = 32'(ua - ub);
      5'd5:  lo_w = 32'(ua / p);
      5'd6: begin
        q = sa / sp;
        if (sa < 0 && (sa % sp) != 0) q = q - 1;
        lo_w = 32'(q);
      end
      5'd7:  lo_w = 32'(ua * p);
      5'd8:  for (int unsigned k = 0; k < 32; k++) lo_w[k] = a[(k + s) % 32];
      5'd9:  for (int unsigned k = 0; k < 32; k++) lo_w[(k + s) % 32] = a[k];
      5'd10, 5'd13: lo_w = a & b;
      5'd11, 5'd14: lo_w = a | b;
      5'd15: {hi_w, lo_w} = 64'(sa * sb);
      5'd16: begin
        if (b == 0) begin
          lo_w = 32'hFFFF_FFFF; hi_w = a;
        end else begin
          q = sa / sb; rm = sa - q * sb;
          lo_w = 32'(q); hi_w = 32'(rm);
        end
      end
      5'd17: lo_w = 32'(64'd0 - ub);
      5'd18: lo_w = ~b;
      default: ;
    endcase
    return {hi_w, lo_w};
  endfunction

  task automatic check_all_zero(input string pfx);
    for (int unsigned i = 0; i < 16; i++) check($sformatf("%s_r%0d", pfx, i), 64'(dut.r[i]), 64'h0);
    check({pfx, "_pc"},  64'(dut.pc),  64'h0);
    check({pfx, "_ir"},  64'(dut.ir),  64'h0);
    check({pfx, "_mar"}, 64'(dut.mar), 64'h0);
    check({pfx, "_mdr"}, 64'(dut.mdr), 64'h0);
    check({pfx, "_y"},   64'(dut.y),   64'h0);
    check({pfx, "_z"},   dut.z,        64'h0);
    check({pfx, "_hi"},  64'(dut.hi),  64'h0);
    check({pfx, "_lo"},  64'(dut.lo),  64'h0);
    check({pfx, "_bus"}, 64'(dut.bus), 64'h0);
  endtask

  initial begin
    logic [63:0] res;
    logic [31:0] a, b, pc_old;
    logic [4:0]  opc;

    idle();
    Mdatain = '0;
    clear = 1;
    tick();
    check_all_zero("init");

    // Fetch
    PCout = 1; MARin = 1;
    tick();
    PCin = 1; IncPC = 1;
    tick();
    mem_to_mdr(32'h2891_8000);
    MDRout = 1; IRin = 1;
    tick();
    check("fetch_mar", 64'(dut.mar), 64'h0);
    check("fetch_pc",  64'(dut.pc),  64'h1);
    check("fetch_ir",  64'(dut.ir),  64'h2891_8000);
    Cout = 1; #1;
    check("cout_pos", 64'(dut.bus), 64'h0001_8000);
    tick();
    mem_to_mdr(32'hFFF7_FFFF);
    MDRout = 1; IRin = 1;
    tick();
    Cout = 1; #1;
    check("cout_neg", 64'(dut.bus), 64'hFFFF_FFFF);
    tick();

    // Divide via register file
    load_reg(6, 32'h14);
    load_reg(7, 32'hFFFF_FFFB);
    Rout[6] = 1; Yin = 1;
    tick();
    Rout[7] = 1; opcode = 5'b10000; Zin = 1;
    tick();
    Zlowout = 1; LOin = 1;
    tick();
    Zhighout = 1; HIin = 1;
    tick();
    check("div_lo", 64'(dut.lo), 64'hFFFF_FFFC);
    check("div_hi", 64'(dut.hi), 64'h0);

    // Multiply
    load_reg(1, 32'hFFFF_FFFE);
    load_reg(3, 32'h3);
    Rout[1] = 1; Yin = 1;
    tick();
    Rout[3] = 1; opcode = 5'b01111; Zin = 1;
    tick();
    check("mul", dut.z, 64'hFFFF_FFFF_FFFF_FFFA);

    // Bus priority
    Rout[3] = 1; Rout[7] = 1; HIout = 1; #1;
    check("prio_r3", 64'(dut.bus), 64'h3);
    tick();
    HIout = 1; Cout = 1; MDRout = 1; #1;
    check("prio_hi", 64'(dut.bus), 64'h0);
    tick();
    LOout = 1; PCout = 1; #1;
    check("prio_lo", 64'(dut.bus), 64'hFFFF_FFFC);
    tick();

    // Shifts and rotates
    alu_run(5'b00101, 32'h8000_0001, 32'h1, res); check("shr",  res, 64'h4000_0000);
    alu_run(5'b00110, 32'h8000_0001, 32'h1, res); check("shra", res, 64'hC000_0000);
    alu_run(5'b00111, 32'h8000_0001, 32'h1, res); check("shl",  res, 64'h0000_0002);
    alu_run(5'b01000, 32'h8000_0001, 32'h1, res); check("ror",  res, 64'hC000_0000);
    alu_run(5'b01001, 32'h8000_0001, 32'h1, res); check("rol",  res, 64'h0000_0003);

    // Divide boundaries
    alu_run(5'b10000, 32'h7, 32'h0, res);
    check("div0", res, 64'h0000_0007_FFFF_FFFF);
    alu_run(5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, res);
    check("divovf", res, 64'h0000_0000_8000_0000);
    alu_run(5'b11111, 32'h1234, 32'h5678, res);
    check("bad_op", res, 64'h0);

    // PC increment wraps; same-cycle read and write of PC
    mem_to_mdr(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1;
    tick();
    PCin = 1; IncPC = 1;
    tick();
    check("pc_wrap", 64'(dut.pc), 64'h0);
    pc_old = dut.pc;
    PCout = 1; PCin = 1; IncPC = 1; Rin[8] = 1;
    tick();
    check("rw_r8", 64'(dut.r[8]), 64'(pc_old));
    check("rw_pc", 64'(dut.pc),   64'(pc_old + 32'd1));

    // MDR from bus
    load_reg(9, 32'hCAFE_0001);
    Rout[9] = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEAD_DEAD;
    tick();
    check("mdr_bus", 64'(dut.mdr), 64'hCAFE_0001);

    // Randomized ALU against reference
    for (int n = 0; n < 48; n++) begin
      opc = 5'($urandom_range(0, 20));
      a   = $urandom;
      b   = (n % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (n % 7 == 0) a = 32'h8000_0000;
      alu_run(opc, a, b, res);
      check($sformatf("rand_op%0d_%h_%h", opc, a, b), res, ref_alu(opc, a, b));
    end

    // Reset priority over enables
    load_reg(5, 32'h1234);
    mem_to_mdr(32'h9);
    MDRout = 1; PCin = 1;
    tick();
    check("pre_r5", 64'(dut.r[5]), 64'h1234);
    check("pre_pc", 64'(dut.pc),   64'h9);
    clear = 1; Rin[5] = 1; MDRout = 1; PCin = 1; Zin = 1; Yin = 1;
    tick();
    check_all_zero("clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
